// File: rtl/sic1_host_io.sv
// sic1_host_io: pin-side I/O controller for the SIC-1 core.
// Serves core reads of @IN and writes to @OUT over a 4-phase
// host handshake, stalling the core until each transfer ends.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   rd_req/rd_done/rd_data  core read of @IN (level req, pulse done)
//   wr_req/wr_data/wr_done  core write of @OUT (level req, pulse done)
//   core_halt            core executed halt; sets sticky halted flag
//   ui_in                host input byte
//   uio_in               [0]=in_valid, [4]=out_ack
//   uo_out               output data register
//   uio_out              [1]=halted, [2]=in_ack, [3]=out_valid
//   uio_oe               constant 8'b0000_1110
module sic1_host_io #(
   parameter int unsigned SYNC_STAGES = 0,
   parameter logic [7:0]  OUT_RESET   = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rd_req,
   output logic       rd_done,
   output logic [7:0] rd_data,
   input  logic       wr_req,
   input  logic [7:0] wr_data,
   output logic       wr_done,
   input  logic       core_halt,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      RD_REL  = 3'd2,
      WR_WAIT = 3'd3,
      WR_REL  = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       rd_done_q, rd_done_d;
   logic       wr_done_q, wr_done_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic [7:0] uo_q, uo_d;
   logic       halted_q, halted_d;
   logic       in_ack_q, in_ack_d;
   logic       out_valid_q, out_valid_d;

   logic       in_valid;
   logic       out_ack;

   // Only in_valid and out_ack are meaningful on uio_in.
   logic       unused_uio;
   assign unused_uio = ^{uio_in[7:5], uio_in[3:1]};

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign in_valid = uio_in[0];
         assign out_ack  = uio_in[4];
      end else begin : g_sync
         logic [1:0] iv_q;
         logic [1:0] oa_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               iv_q <= 2'b00;
               oa_q <= 2'b00;
            end else begin
               iv_q <= {iv_q[0], uio_in[0]};
               oa_q <= {oa_q[0], uio_in[4]};
            end
         end
         assign in_valid = iv_q[1];
         assign out_ack  = oa_q[1];
      end
   endgenerate

   // Halted only gates new requests in IDLE, so a transfer already
   // in flight when the core halts still runs to completion.
   assign halted_d = halted_q | core_halt;

   always_comb begin
      state_d     = state_q;
      rd_done_d   = 1'b0;
      wr_done_d   = 1'b0;
      rd_data_d   = rd_data_q;
      uo_d        = uo_q;
      in_ack_d    = in_ack_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (!halted_q) begin
               if (rd_req) begin
                  state_d = RD_WAIT;
               end else if (wr_req) begin
                  uo_d        = wr_data;
                  out_valid_d = 1'b1;
                  state_d     = WR_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (in_valid) begin
               rd_data_d = ui_in;
               rd_done_d = 1'b1;
               in_ack_d  = 1'b1;
               state_d   = RD_REL;
            end
         end
         RD_REL: begin
            if (!in_valid) begin
               in_ack_d = 1'b0;
               state_d  = IDLE;
            end
         end
         WR_WAIT: begin
            if (out_ack) begin
               out_valid_d = 1'b0;
               wr_done_d   = 1'b1;
               state_d     = WR_REL;
            end
         end
         WR_REL: begin
            // Returning to IDLE only once out_ack is low means the
            // next write can never see a stale acknowledge.
            if (!out_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rd_done_q   <= 1'b0;
         wr_done_q   <= 1'b0;
         rd_data_q   <= 8'h00;
         uo_q        <= OUT_RESET;
         halted_q    <= 1'b0;
         in_ack_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_done_q   <= rd_done_d;
         wr_done_q   <= wr_done_d;
         rd_data_q   <= rd_data_d;
         uo_q        <= uo_d;
         halted_q    <= halted_d;
         in_ack_q    <= in_ack_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign rd_done = rd_done_q;
   assign wr_done = wr_done_q;
   assign rd_data = rd_data_q;
   assign uo_out  = uo_q;
   assign uio_out = {4'b0000, out_valid_q, in_ack_q, halted_q, 1'b0};
   assign uio_oe  = 8'b0000_1110;

endmodule

// File: tb/tb_sic1_host_io.sv
// tb_sic1_host_io: scoreboard bench for sic1_host_io.
// Instance 0 uses SYNC_STAGES=0, instance 1 uses SYNC_STAGES=2.
module tb_sic1_host_io;

   typedef struct packed {
      logic       is_wr;
      logic [7:0] d;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       rd_req_a  [2];
   logic [7:0] ui_a      [2];
   logic [7:0] uioi_a    [2];
   logic       rd_done_a [2];
   logic [7:0] rd_data_a [2];
   logic [7:0] uo_a      [2];
   logic [7:0] uioo_a    [2];
   logic [7:0] oe_a      [2];
   logic       wr_req;
   logic [7:0] wr_data;
   logic       wr_done;
   logic       wr_done1;
   logic       core_halt;

   exp_t sb0[$];
   exp_t sb1[$];

   int n_cmp = 0;
   int n_bad = 0;

   sic1_host_io #(.SYNC_STAGES(0), .OUT_RESET(8'h00)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_req    (rd_req_a[0]),
      .rd_done   (rd_done_a[0]),
      .rd_data   (rd_data_a[0]),
      .wr_req    (wr_req),
      .wr_data   (wr_data),
      .wr_done   (wr_done),
      .core_halt (core_halt),
      .ui_in     (ui_a[0]),
      .uio_in    (uioi_a[0]),
      .uo_out    (uo_a[0]),
      .uio_out   (uioo_a[0]),
      .uio_oe    (oe_a[0])
   );

   sic1_host_io #(.SYNC_STAGES(2), .OUT_RESET(8'h00)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_req    (rd_req_a[1]),
      .rd_done   (rd_done_a[1]),
      .rd_data   (rd_data_a[1]),
      .wr_req    (1'b0),
      .wr_data   (8'h00),
      .wr_done   (wr_done1),
      .core_halt (1'b0),
      .ui_in     (ui_a[1]),
      .uio_in    (uioi_a[1]),
      .uo_out    (uo_a[1]),
      .uio_out   (uioo_a[1]),
      .uio_oe    (oe_a[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every done pulse must match the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (rd_done_a[0] | wr_done)
            check("done_excl", rd_done_a[0] & wr_done, 1'b0);
         if (rd_done_a[0]) begin
            if (sb0.size() == 0) begin
               check("rd_unexpected0", rd_done_a[0], 1'b0);
            end else begin
               e = sb0.pop_front();
               check("sb_kind_rd0", e.is_wr, 1'b0);
               check("sb_rd_data0", rd_data_a[0], e.d);
            end
         end
         if (wr_done) begin
            if (sb0.size() == 0) begin
               check("wr_unexpected0", wr_done, 1'b0);
            end else begin
               e = sb0.pop_front();
               check("sb_kind_wr0", e.is_wr, 1'b1);
               check("sb_uo_out0", uo_a[0], e.d);
            end
         end
         if (rd_done_a[1]) begin
            if (sb1.size() == 0) begin
               check("rd_unexpected1", rd_done_a[1], 1'b0);
            end else begin
               e = sb1.pop_front();
               check("sb_kind_rd1", e.is_wr, 1'b0);
               check("sb_rd_data1", rd_data_a[1], e.d);
            end
         end
         if (wr_done1)
            check("wr_unexpected1", wr_done1, 1'b0);
      end
   end

   task automatic do_read(input int s, input logic [7:0] d,
                          input int dly, input int exp_lat,
                          input int exp_fall);
      int lat;
      int n;
      rd_req_a[s] = 1'b1;
      if (s == 0) sb0.push_back('{1'b0, d});
      else        sb1.push_back('{1'b0, d});
      lat = 0;
      repeat (dly) begin
         tick();
         lat++;
      end
      ui_a[s] = d;
      uioi_a[s][0] = 1'b1;
      while (!rd_done_a[s] && lat < 50) begin
         tick();
         lat++;
      end
      check("rd_done_seen", rd_done_a[s], 1'b1);
      check("rd_latency", lat, exp_lat);
      check("in_ack_with_done", uioo_a[s][2], 1'b1);
      rd_req_a[s] = 1'b0;
      uioi_a[s][0] = 1'b0;
      ui_a[s] = 8'h00;
      n = 0;
      while (uioo_a[s][2] && n < 50) begin
         tick();
         n++;
      end
      check("in_ack_fall_lat", n, exp_fall);
      check("rd_data_held", rd_data_a[s], d);
   endtask

   task automatic do_write(input logic [7:0] d);
      int n;
      wr_req = 1'b1;
      wr_data = d;
      sb0.push_back('{1'b1, d});
      n = 0;
      while (!uioo_a[0][3] && n < 20) begin
         tick();
         n++;
      end
      check("wr_out_valid_lat", n, 1);
      check("wr_uo_out", uo_a[0], d);
      wr_data = ~d;
      uioi_a[0][4] = 1'b1;
      n = 0;
      while (!wr_done && n < 20) begin
         tick();
         n++;
      end
      check("wr_done_seen", wr_done, 1'b1);
      check("wr_out_valid_clr", uioo_a[0][3], 1'b0);
      wr_req = 1'b0;
      uioi_a[0][4] = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      rst_n = 1'b0;
      wr_req = 1'b0;
      wr_data = 8'h00;
      core_halt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd_req_a[i] = 1'b0;
         ui_a[i] = 8'h00;
         uioi_a[i] = 8'h00;
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_uo_out", uo_a[0], 8'h00);
      check("rst_uio_out", uioo_a[0], 8'h00);
      check("rst_uio_oe", oe_a[0], 8'h0E);
      check("rst_rd_done", rd_done_a[0], 1'b0);
      check("rst_wr_done", wr_done, 1'b0);
      check("rst_rd_data", rd_data_a[0], 8'h00);
      rst_n = 1'b1;
      tick();

      // Reset with a read parked in RD_REL.
      do_write(8'h77);
      rd_req_a[0] = 1'b1;
      ui_a[0] = 8'h99;
      uioi_a[0][0] = 1'b1;
      sb0.push_back('{1'b0, 8'h99});
      n = 0;
      while (!rd_done_a[0] && n < 50) begin
         tick();
         n++;
      end
      check("t1_rd_done", rd_done_a[0], 1'b1);
      @(negedge clk);
      #1;
      check("t1_in_ack_inflight", uioo_a[0][2], 1'b1);
      rst_n = 1'b0;
      #1;
      check("t1_uo_out", uo_a[0], 8'h00);
      check("t1_uio_out", uioo_a[0], 8'h00);
      check("t1_uio_oe", oe_a[0], 8'h0E);
      check("t1_rd_data", rd_data_a[0], 8'h00);
      rd_req_a[0] = 1'b0;
      uioi_a[0][0] = 1'b0;
      ui_a[0] = 8'h00;
      tick();
      rst_n = 1'b1;
      tick();

      // Read, host answers after 3 cycles; then minimum-latency read.
      do_read(0, 8'hA5, 3, 4, 1);
      do_read(0, 8'h42, 0, 2, 1);

      // Writes; uo_out holds between them.
      do_write(8'h3C);
      repeat (5) tick();
      check("t3_uo_hold", uo_a[0], 8'h3C);
      check("t3_out_valid_idle", uioo_a[0][3], 1'b0);
      do_write(8'h81);

      // Simultaneous read and write: read goes first.
      rd_req_a[0] = 1'b1;
      wr_req = 1'b1;
      wr_data = 8'h5A;
      ui_a[0] = 8'h11;
      uioi_a[0][0] = 1'b1;
      sb0.push_back('{1'b0, 8'h11});
      sb0.push_back('{1'b1, 8'h5A});
      n = 0;
      while (!rd_done_a[0] && n < 50) begin
         tick();
         n++;
      end
      check("t4_rd_first", rd_done_a[0], 1'b1);
      check("t4_uo_not_yet", uo_a[0], 8'h81);
      check("t4_no_out_valid", uioo_a[0][3], 1'b0);
      rd_req_a[0] = 1'b0;
      uioi_a[0][0] = 1'b0;
      n = 0;
      while (!uioo_a[0][3] && n < 20) begin
         tick();
         n++;
      end
      check("t4_wr_after_rd_lat", n, 2);
      check("t4_uo_out", uo_a[0], 8'h5A);
      uioi_a[0][4] = 1'b1;
      n = 0;
      while (!wr_done && n < 20) begin
         tick();
         n++;
      end
      check("t4_wr_done", wr_done, 1'b1);
      wr_req = 1'b0;
      uioi_a[0][4] = 1'b0;
      tick();

      // Synchronised instance: two cycles later than instance 0.
      do_read(1, 8'hA5, 3, 6, 3);

      // Halt while a write is in flight.
      wr_req = 1'b1;
      wr_data = 8'hC3;
      sb0.push_back('{1'b1, 8'hC3});
      n = 0;
      while (!uioo_a[0][3] && n < 20) begin
         tick();
         n++;
      end
      check("t5_out_valid", uioo_a[0][3], 1'b1);
      core_halt = 1'b1;
      tick();
      core_halt = 1'b0;
      check("t5_halted_set", uioo_a[0][1], 1'b1);
      check("t5_still_valid", uioo_a[0][3], 1'b1);
      uioi_a[0][4] = 1'b1;
      n = 0;
      while (!wr_done && n < 20) begin
         tick();
         n++;
      end
      check("t5_wr_done", wr_done, 1'b1);
      wr_req = 1'b0;
      uioi_a[0][4] = 1'b0;
      tick();
      check("t5_host_halt", uioo_a[0][1] & oe_a[0][1], 1'b1);
      rd_req_a[0] = 1'b1;
      ui_a[0] = 8'hEE;
      uioi_a[0][0] = 1'b1;
      bad = 0;
      repeat (100) begin
         tick();
         if (uioo_a[0][2] || rd_done_a[0]) bad++;
      end
      check("t5_no_service", bad, 0);
      check("t5_uo_kept", uo_a[0], 8'hC3);
      check("t5_still_halted", uioo_a[0][1], 1'b1);
      rd_req_a[0] = 1'b0;
      uioi_a[0][0] = 1'b0;
      repeat (2) tick();

      @(negedge clk);
      #1;
      check("sb0_drained", sb0.size(), 0);
      check("sb1_drained", sb1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
